// File: rtl/iob_reset_sequencer_pkg.sv
// Shared types and defaults for the staggered multi-domain reset sequencer.
package iob_reset_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_READY = 3'd1,
    ST_HOLD       = 3'd2,
    ST_RELEASE    = 3'd3,
    ST_DONE       = 3'd4
  } state_t;

  localparam int unsigned DEF_N_CH     = 3;
  localparam int unsigned DEF_DURATION = 10;
  localparam int unsigned DEF_STEP     = 4;
  localparam int unsigned DEF_TIMEOUT  = 1000000;
  localparam int unsigned DEF_CNT_W    = 24;

  // Channel index width, never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iob_reset_seq_cnt.sv
// Loadable down-counter with clock enable; saturates at zero.
module iob_reset_seq_cnt
  import iob_reset_sequencer_pkg::*;
#(
  parameter int unsigned W = DEF_CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cke_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (cke_i) begin
      if (load_i) begin
        r_cnt <= load_val_i;
      end else if (dec_i && (r_cnt != '0)) begin
        r_cnt <= r_cnt - W'(1);
      end
    end
  end

  assign zero_o = (r_cnt == '0);

endmodule

// File: rtl/iob_reset_sequencer.sv
// Staggered reset release after PLL lock and DDR calibration; reasserts all on loss.
// Optional WAIT_READY watchdog enabled by defining IOB_RESET_SEQ_WDOG_EN.
module iob_reset_sequencer
  import iob_reset_sequencer_pkg::*;
#(
  parameter int unsigned N_CH     = DEF_N_CH,
  parameter int unsigned DURATION = DEF_DURATION,
  parameter int unsigned STEP     = DEF_STEP,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cke_i,
  input  logic            start_i,
  input  logic            locked_i,
  input  logic            calib_done_i,
  output logic [N_CH-1:0] rst_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            timeout_o
);

  localparam int unsigned CH_W = idx_width(N_CH);

  if ((N_CH < 1) || (N_CH > 8) || (DURATION < 1) || (STEP < 1) ||
      (64'(DURATION) >= (64'd1 << CNT_W)) || (64'(STEP) >= (64'd1 << CNT_W)) ||
      (64'(TIMEOUT) >= (64'd1 << CNT_W))) begin : g_param_err
    $error("iob_reset_sequencer: illegal parameter set");
  end

  state_t          r_state;
  state_t          w_state_nxt;
  logic [N_CH-1:0] r_rst;
  logic [N_CH-1:0] w_rst_nxt;
  logic [CH_W-1:0] r_ch;
  logic [CH_W-1:0] w_ch_nxt;
  logic            r_done;
  logic            w_done_nxt;
  logic            r_busy;
  logic            w_busy_nxt;
  logic            w_ready;
  logic            w_last_ch;
  logic            w_cnt_zero;
  logic            w_cnt_load;
  logic            w_cnt_dec;
  logic [CNT_W-1:0] w_cnt_val;

  assign w_ready   = locked_i & calib_done_i;
  assign w_last_ch = (r_ch == CH_W'(N_CH - 2));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else if (cke_i) begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and shared HOLD/RELEASE counter control.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_load  = 1'b0;
    w_cnt_dec   = 1'b0;
    w_cnt_val   = '0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) w_state_nxt = ST_WAIT_READY;
      end
      ST_WAIT_READY: begin
        if (w_ready) begin
          w_state_nxt = ST_HOLD;
          w_cnt_load  = 1'b1;
          w_cnt_val   = CNT_W'(DURATION - 1);
        end
      end
      ST_HOLD: begin
        if (!w_ready) begin
          w_state_nxt = ST_WAIT_READY;
          w_cnt_load  = 1'b1;
        end else if (w_cnt_zero) begin
          w_state_nxt = (N_CH == 1) ? ST_DONE : ST_RELEASE;
          w_cnt_load  = 1'b1;
          w_cnt_val   = CNT_W'(STEP - 1);
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!w_ready) begin
          w_state_nxt = ST_WAIT_READY;
          w_cnt_load  = 1'b1;
        end else if (w_cnt_zero) begin
          w_state_nxt = w_last_ch ? ST_DONE : ST_RELEASE;
          w_cnt_load  = 1'b1;
          w_cnt_val   = CNT_W'(STEP - 1);
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ST_DONE: begin
        if (!w_ready) begin
          w_state_nxt = ST_WAIT_READY;
          w_cnt_load  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output next values: releases shift a zero in from bit 0.
  always_comb begin
    w_rst_nxt = r_rst;
    w_ch_nxt  = r_ch;
    if ((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_WAIT_READY)) begin
      w_rst_nxt = '1;
      w_ch_nxt  = '0;
    end else if ((r_state == ST_HOLD) && (w_state_nxt != ST_HOLD)) begin
      w_rst_nxt = r_rst << 1;
      w_ch_nxt  = '0;
    end else if ((r_state == ST_RELEASE) && w_cnt_zero) begin
      w_rst_nxt = r_rst << 1;
      w_ch_nxt  = r_ch + CH_W'(1);
    end
    w_done_nxt = (w_state_nxt == ST_DONE);
    w_busy_nxt = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rst  <= '1;
      r_ch   <= '0;
      r_done <= 1'b0;
      r_busy <= 1'b0;
    end else if (cke_i) begin
      r_rst  <= w_rst_nxt;
      r_ch   <= w_ch_nxt;
      r_done <= w_done_nxt;
      r_busy <= w_busy_nxt;
    end
  end

  iob_reset_seq_cnt #(.W(CNT_W)) u_step_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cke_i      (cke_i),
    .load_i     (w_cnt_load),
    .load_val_i (w_cnt_val),
    .dec_i      (w_cnt_dec),
    .zero_o     (w_cnt_zero)
  );

`ifdef IOB_RESET_SEQ_WDOG_EN
  logic w_wd_zero;
  logic w_wd_load;
  logic w_wd_dec;
  logic r_timeout;

  // Reload on every entry into WAIT_READY; flag is sticky until rst_i.
  assign w_wd_load = (r_state != ST_WAIT_READY) && (w_state_nxt == ST_WAIT_READY);
  assign w_wd_dec  = (r_state == ST_WAIT_READY);

  iob_reset_seq_cnt #(.W(CNT_W)) u_wdog_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cke_i      (cke_i),
    .load_i     (w_wd_load),
    .load_val_i (CNT_W'(TIMEOUT - 1)),
    .dec_i      (w_wd_dec),
    .zero_o     (w_wd_zero)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_timeout <= 1'b0;
    end else if (cke_i && w_wd_dec && w_wd_zero && !w_ready) begin
      r_timeout <= 1'b1;
    end
  end

  assign timeout_o = r_timeout;
`else
  assign timeout_o = 1'b0;
`endif

  assign rst_o  = r_rst;
  assign busy_o = r_busy;
  assign done_o = r_done;

endmodule

// File: tb/tb_iob_reset_sequencer.sv
// Directed bench for iob_reset_sequencer (N_CH=3, DURATION=10, STEP=4).
module tb_iob_reset_sequencer;

  localparam int unsigned N_CH     = 3;
  localparam int unsigned DURATION = 10;
  localparam int unsigned STEP     = 4;
  localparam int unsigned TIMEOUT  = 20;
  localparam int unsigned CNT_W    = 24;

`ifdef IOB_RESET_SEQ_WDOG_EN
  localparam logic EXP_TO = 1'b1;
`else
  localparam logic EXP_TO = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_i;
  logic            cke_i;
  logic            start_i;
  logic            locked_i;
  logic            calib_done_i;
  logic [N_CH-1:0] rst_o;
  logic            busy_o;
  logic            done_o;
  logic            timeout_o;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  iob_reset_sequencer #(
    .N_CH(N_CH), .DURATION(DURATION), .STEP(STEP), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .cke_i        (cke_i),
    .start_i      (start_i),
    .locked_i     (locked_i),
    .calib_done_i (calib_done_i),
    .rst_o        (rst_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  // Outputs are observed 1 time unit after the edge that ends the previous cycle.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset(input logic lk, input logic cd);
    rst_i = 1'b1; cke_i = 1'b1; start_i = 1'b0; locked_i = lk; calib_done_i = cd;
    step();
    step();
    rst_i = 1'b0;
    cyc   = 0;
  endtask

  task automatic pulse_start(input int at);
    run_to(at);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [N_CH-1:0] e_rst, input logic e_done);
    chk({tag, "_rst"}, 32'(rst_o), 32'(e_rst));
    chk({tag, "_done"}, 32'(done_o), 32'(e_done));
  endtask

  initial begin
    // Basic sequence, ignored start in DONE, loss/recovery via calib_done.
    do_reset(1'b1, 1'b1);
    chk_out("rst0", 3'b111, 1'b0);
    chk("rst0_busy", 32'(busy_o), 32'd0);
    chk("rst0_to", 32'(timeout_o), 32'd0);
    run_to(4);
    chk_out("idle4", 3'b111, 1'b0);
    pulse_start(5);
    chk("s1_busy6", 32'(busy_o), 32'd1);
    run_to(16); chk_out("s1_16", 3'b111, 1'b0);
    run_to(17); chk_out("s1_17", 3'b110, 1'b0);
    run_to(20); chk_out("s1_20", 3'b110, 1'b0);
    run_to(21); chk_out("s1_21", 3'b100, 1'b0);
    run_to(24); chk_out("s1_24", 3'b100, 1'b0);
    chk("s1_busy24", 32'(busy_o), 32'd1);
    run_to(25); chk_out("s1_25", 3'b000, 1'b1);
    chk("s1_busy25", 32'(busy_o), 32'd0);
    pulse_start(40);
    run_to(45); chk_out("s1_45", 3'b000, 1'b1);
    run_to(60); calib_done_i = 1'b0;
    step();     chk_out("s1_61", 3'b111, 1'b0);
    chk("s1_busy61", 32'(busy_o), 32'd1);
    run_to(70); calib_done_i = 1'b1;
    run_to(80); chk_out("s1_80", 3'b111, 1'b0);
    run_to(81); chk_out("s1_81", 3'b110, 1'b0);
    chk("s1_to81", 32'(timeout_o), 32'd0);

    // Late PLL lock; watchdog observation while waiting.
    do_reset(1'b0, 1'b1);
    pulse_start(5);
    run_to(29); chk_out("s2_29", 3'b111, 1'b0);
    chk("s2_busy29", 32'(busy_o), 32'd1);
    chk("s2_to29", 32'(timeout_o), 32'(EXP_TO));
    run_to(30); locked_i = 1'b1;
    run_to(40); chk_out("s2_40", 3'b111, 1'b0);
    run_to(41); chk_out("s2_41", 3'b110, 1'b0);
    run_to(45); chk_out("s2_45", 3'b100, 1'b0);
    run_to(48); chk_out("s2_48", 3'b100, 1'b0);
    run_to(49); chk_out("s2_49", 3'b000, 1'b1);
    chk("s2_to49", 32'(timeout_o), 32'(EXP_TO));

    // One-cycle lock drop during RELEASE; start pulses mid-sequence ignored.
    do_reset(1'b1, 1'b1);
    pulse_start(5);
    run_to(17); chk_out("s3_17", 3'b110, 1'b0);
    pulse_start(18);
    run_to(19); locked_i = 1'b0;
    step();     locked_i = 1'b1;
    chk_out("s3_20", 3'b111, 1'b0);
    pulse_start(22);
    run_to(30); chk_out("s3_30", 3'b111, 1'b0);
    run_to(31); chk_out("s3_31", 3'b110, 1'b0);
    run_to(35); chk_out("s3_35", 3'b100, 1'b0);
    run_to(38); chk_out("s3_38", 3'b100, 1'b0);
    run_to(39); chk_out("s3_39", 3'b000, 1'b1);

    // Seven frozen cycles in HOLD, then rst_i (with cke_i low) mid-RELEASE.
    do_reset(1'b1, 1'b1);
    pulse_start(5);
    run_to(10); cke_i = 1'b0;
    run_to(17); cke_i = 1'b1;
    chk_out("s4_17", 3'b111, 1'b0);
    run_to(23); chk_out("s4_23", 3'b111, 1'b0);
    run_to(24); chk_out("s4_24", 3'b110, 1'b0);
    run_to(27); chk_out("s4_27", 3'b110, 1'b0);
    run_to(28); chk_out("s4_28", 3'b100, 1'b0);
    run_to(30); rst_i = 1'b1; cke_i = 1'b0;
    step();     rst_i = 1'b0; cke_i = 1'b1;
    chk_out("s4_31", 3'b111, 1'b0);
    chk("s4_busy31", 32'(busy_o), 32'd0);
    chk("s4_to31", 32'(timeout_o), 32'd0);
    run_to(50); chk_out("s4_50", 3'b111, 1'b0);
    chk("s4_busy50", 32'(busy_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
